// File: rtl/rx_event_counter_bank_pkg.sv
// Shared definitions for the receiver event counter bank: default sizing,
// receiver event line indices and the default configuration register bit map.
package rx_event_counter_bank_pkg;

  localparam int DEF_NUM_EVENTS    = 8;
  localparam int DEF_NUM_COUNTERS  = 4;
  localparam int DEF_COUNTER_WIDTH = 22;
  localparam int DEF_SEL_WIDTH     = 3;
  localparam int DEF_IDX_WIDTH     = 2;

  typedef enum logic [2:0] {
    EV_POWER_TRIG = 3'd0,
    EV_SHORT_PRE  = 3'd1,
    EV_LONG_PRE   = 3'd2,
    EV_SIG_VALID  = 3'd3,
    EV_FCS_OK     = 3'd4,
    EV_FCS_FAIL   = 3'd5,
    EV_RX_RST     = 3'd6,
    EV_SPARE      = 3'd7
  } rx_event_e;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_e;

  // Default placement of the configuration fields in the AXI-lite config word
  localparam int REG_EDGE_MODE_LSB  = 0;
  localparam int REG_EVENT_SEL_LSB  = 8;
  localparam int REG_SAT_MODE_BIT   = 20;
  localparam int REG_CNT_ENABLE_LSB = 24;
  localparam int REG_CLEAR_LSB      = 28;

endpackage

// File: rtl/rx_event_counter_bank_if.sv
// Configuration, event and read-back signals between the register slice /
// dot11 status strobes (master) and the counter bank (slave).
interface rx_event_counter_bank_if
  import rx_event_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS    = DEF_NUM_EVENTS,
  parameter int NUM_COUNTERS  = DEF_NUM_COUNTERS,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
  parameter int IDX_WIDTH     = DEF_IDX_WIDTH
) ();

  logic [NUM_EVENTS-1:0]             event_in;
  logic [NUM_EVENTS-1:0]             edge_mode;
  logic [NUM_COUNTERS-1:0]           cnt_enable;
  logic [NUM_COUNTERS*SEL_WIDTH-1:0] event_sel;
  logic                              sat_mode;
  logic [NUM_COUNTERS-1:0]           clear;
  logic                              snapshot;
  logic [IDX_WIDTH-1:0]              rd_idx;
  logic [COUNTER_WIDTH-1:0]          rd_data;
  logic [COUNTER_WIDTH-1:0]          alarm_th;
  logic [NUM_COUNTERS-1:0]           alarm;
  logic [NUM_COUNTERS-1:0]           overflow_flag;

  modport master (
    output event_in, edge_mode, cnt_enable, event_sel, sat_mode,
    output clear, snapshot, rd_idx, alarm_th,
    input  rd_data, alarm, overflow_flag
  );

  modport slave (
    input  event_in, edge_mode, cnt_enable, event_sel, sat_mode,
    input  clear, snapshot, rd_idx, alarm_th,
    output rd_data, alarm, overflow_flag
  );

endinterface

// File: rtl/rx_event_counter_cell.sv
// One live event counter: enable, clear, saturate/wrap handling, threshold
// alarm pulse and sticky overflow flag. All outputs are registered.
module rx_event_counter_cell
  import rx_event_counter_bank_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     clear,
  input  logic                     sat_mode,
  input  logic [COUNTER_WIDTH-1:0] alarm_th,
  output logic [COUNTER_WIDTH-1:0] value,
  output logic                     alarm,
  output logic                     overflow_flag
);

  logic [COUNTER_WIDTH:0]   sum_s;
  logic                     carry_s;
  logic [COUNTER_WIDTH-1:0] value_next_s;
  logic                     alarm_next_s;
  logic                     ovf_next_s;

  logic [COUNTER_WIDTH-1:0] value_r;
  logic                     alarm_r;
  logic                     ovf_r;

  // Next-state: clear wins over a hit; the carry out of the widened sum marks an all-ones increment
  always_comb begin
    sum_s        = {1'b0, value_r} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    carry_s      = sum_s[COUNTER_WIDTH];
    value_next_s = value_r;
    alarm_next_s = 1'b0;
    ovf_next_s   = ovf_r;
    if (clear) begin
      value_next_s = {COUNTER_WIDTH{1'b0}};
      ovf_next_s   = 1'b0;
    end else if (inc) begin
      if (carry_s) begin
        ovf_next_s = 1'b1;
        if (cnt_mode_e'(sat_mode) == CNT_SATURATE) begin
          value_next_s = value_r;
        end else begin
          value_next_s = {COUNTER_WIDTH{1'b0}};
        end
      end else begin
        value_next_s = sum_s[COUNTER_WIDTH-1:0];
        alarm_next_s = (alarm_th != {COUNTER_WIDTH{1'b0}}) &&
                       (sum_s[COUNTER_WIDTH-1:0] == alarm_th);
      end
    end else begin
      value_next_s = value_r;
    end
  end

  // Counter, alarm and overflow state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_r <= {COUNTER_WIDTH{1'b0}};
      alarm_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      value_r <= value_next_s;
      alarm_r <= alarm_next_s;
      ovf_r   <= ovf_next_s;
    end
  end

  assign value         = value_r;
  assign alarm         = alarm_r;
  assign overflow_flag = ovf_r;

endmodule

// File: rtl/rx_event_counter_bank.sv
// Bank of independent receiver event counters with per-line edge/level
// detection, per-counter event select, atomic snapshot shadows and a read mux.
module rx_event_counter_bank
  import rx_event_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS    = DEF_NUM_EVENTS,
  parameter int NUM_COUNTERS  = DEF_NUM_COUNTERS,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
  parameter int IDX_WIDTH     = DEF_IDX_WIDTH
) (
  input logic                   clock,
  input logic                   reset,
  rx_event_counter_bank_if.slave bus
);

  logic [NUM_EVENTS-1:0]    event_d_r;
  logic [NUM_EVENTS-1:0]    hit_s;
  logic [SEL_WIDTH-1:0]     sel_s    [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  inc_s;
  logic [COUNTER_WIDTH-1:0] live_s   [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] shadow_r [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] rd_next_s;
  logic [COUNTER_WIDTH-1:0] rd_data_r;
  logic [NUM_COUNTERS-1:0]  alarm_s;
  logic [NUM_COUNTERS-1:0]  ovf_s;

  // Per-line hit: rising edge against last cycle's level, or the level itself
  always_comb begin
    hit_s = {NUM_EVENTS{1'b0}};
    for (int e = 0; e < NUM_EVENTS; e++) begin
      hit_s[e] = bus.edge_mode[e] ? (bus.event_in[e] & ~event_d_r[e]) : bus.event_in[e];
    end
  end

  // Event mux per counter; select codes at or beyond NUM_EVENTS match no line
  always_comb begin
    inc_s = {NUM_COUNTERS{1'b0}};
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      sel_s[k] = bus.event_sel[k*SEL_WIDTH +: SEL_WIDTH];
      for (int e = 0; e < NUM_EVENTS; e++) begin
        inc_s[k] = inc_s[k] | (hit_s[e] & (int'(sel_s[k]) == e));
      end
      inc_s[k] = inc_s[k] & bus.cnt_enable[k];
    end
  end

  // Read mux over the shadows; an index past the last counter reads zero
  always_comb begin
    rd_next_s = {COUNTER_WIDTH{1'b0}};
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (int'(bus.rd_idx) == k) begin
        rd_next_s = shadow_r[k];
      end else begin
        rd_next_s = rd_next_s;
      end
    end
  end

  // Event history, snapshot shadows (pre-update live values) and registered read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_d_r <= {NUM_EVENTS{1'b0}};
      rd_data_r <= {COUNTER_WIDTH{1'b0}};
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        shadow_r[k] <= {COUNTER_WIDTH{1'b0}};
      end
    end else begin
      event_d_r <= bus.event_in;
      rd_data_r <= rd_next_s;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if (bus.snapshot) begin
          shadow_r[k] <= live_s[k];
        end else begin
          shadow_r[k] <= shadow_r[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_cell
    rx_event_counter_cell #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_cell (
      .clock         (clock),
      .reset         (reset),
      .inc           (inc_s[k]),
      .clear         (bus.clear[k]),
      .sat_mode      (bus.sat_mode),
      .alarm_th      (bus.alarm_th),
      .value         (live_s[k]),
      .alarm         (alarm_s[k]),
      .overflow_flag (ovf_s[k])
    );
  end

  assign bus.rd_data       = rd_data_r;
  assign bus.alarm         = alarm_s;
  assign bus.overflow_flag = ovf_s;

endmodule

// File: tb/tb_rx_event_counter_bank.sv
// Scoreboard bench for rx_event_counter_bank: directed scenarios plus random
// traffic, checked every cycle against an integer model of the counting rules.
module tb_rx_event_counter_bank;

  localparam int NE   = 6;
  localparam int NC   = 3;
  localparam int CW   = 6;
  localparam int SW   = 3;
  localparam int IW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rx_event_counter_bank_if #(.NUM_EVENTS(NE), .NUM_COUNTERS(NC), .COUNTER_WIDTH(CW),
                             .SEL_WIDTH(SW), .IDX_WIDTH(IW)) bus ();

  rx_event_counter_bank #(.NUM_EVENTS(NE), .NUM_COUNTERS(NC), .COUNTER_WIDTH(CW),
                          .SEL_WIDTH(SW), .IDX_WIDTH(IW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus variables
  logic [NE-1:0]    ev_v, em_v;
  logic [NC-1:0]    en_v, clr_v;
  logic [NC*SW-1:0] sel_v;
  logic             sat_v, snap_v;
  logic [IW-1:0]    idx_v;
  logic [CW-1:0]    th_v;

  // reference model state
  int live_m   [NC];
  int shadow_m [NC];
  bit evd_m    [NE];
  bit ovf_m    [NC];

  typedef struct {
    int            cyc;
    int            rd;
    logic [NC-1:0] al;
    logic [NC-1:0] ov;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic drive();
    bus.event_in   = ev_v;
    bus.edge_mode  = em_v;
    bus.cnt_enable = en_v;
    bus.event_sel  = sel_v;
    bus.sat_mode   = sat_v;
    bus.clear      = clr_v;
    bus.snapshot   = snap_v;
    bus.rd_idx     = idx_v;
    bus.alarm_th   = th_v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin live_m[k] = 0; shadow_m[k] = 0; ovf_m[k] = 0; end
    for (int e = 0; e < NE; e++) evd_m[e] = 0;
  endtask

  // Apply this cycle's inputs, advance the model one clock, queue the expected outputs
  task automatic step();
    exp_t e;
    bit   hit [NE];
    int   old_live [NC];
    int   sel;
    int   idx;
    drive();
    e.cyc = cyc + 1;
    idx   = int'(idx_v);
    e.rd  = 0;
    if (idx < NC) e.rd = shadow_m[idx];
    for (int i = 0; i < NE; i++) hit[i] = em_v[i] ? (ev_v[i] && !evd_m[i]) : ev_v[i];
    for (int k = 0; k < NC; k++) begin
      old_live[k] = live_m[k];
      e.al[k] = 1'b0;
      sel = int'(sel_v[k*SW +: SW]);
      if (clr_v[k]) begin
        live_m[k] = 0;
        ovf_m[k]  = 0;
      end else if (en_v[k] && sel < NE && hit[sel]) begin
        if (live_m[k] == MAXV) begin
          ovf_m[k] = 1;
          if (!sat_v) live_m[k] = 0;
        end else begin
          live_m[k] = live_m[k] + 1;
          if (int'(th_v) != 0 && live_m[k] == int'(th_v)) e.al[k] = 1'b1;
        end
      end
      e.ov[k] = ovf_m[k];
    end
    if (snap_v) for (int k = 0; k < NC; k++) shadow_m[k] = old_live[k];
    for (int i = 0; i < NE; i++) evd_m[i] = ev_v[i];
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic set_sel(input int k, input int v);
    sel_v[k*SW +: SW] = SW'(v);
  endtask

  task automatic rd(input int idx, output int val);
    idx_v = IW'(idx);
    step();
    val = int'(bus.rd_data);
  endtask

  task automatic snap();
    snap_v = 1'b1; step(); snap_v = 1'b0;
  endtask

  task automatic clr(input logic [NC-1:0] m);
    clr_v = m; step(); clr_v = '0;
  endtask

  // Monitor: compare outputs every cycle the scoreboard has an entry due
  always @(negedge clock) begin
    if (!reset && sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_rd_data", int'(bus.rd_data), e.rd);
      chk("sb_alarm", int'(bus.alarm), int'(e.al));
      chk("sb_overflow", int'(bus.overflow_flag), int'(e.ov));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int v, cnt, pos;
    ev_v = '0; em_v = '0; en_v = '0; clr_v = '0; sel_v = '0;
    sat_v = 1'b0; snap_v = 1'b0; idx_v = '0; th_v = '0;
    model_reset();
    drive();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rd_data", int'(bus.rd_data), 0);
    chk("reset_alarm", int'(bus.alarm), 0);
    chk("reset_overflow", int'(bus.overflow_flag), 0);
    reset = 1'b0;

    // level vs edge on the same waveform (lines 2 and 3)
    set_sel(0, 2); set_sel(1, 3); en_v = 3'b011; em_v = 6'b001000;
    ev_v = 6'b001100; repeat (5) step();
    ev_v = '0; snap();
    rd(0, v); chk("level_count", v, 5);
    rd(1, v); chk("edge_count", v, 1);

    // saturate, wrap and clear on counter 0
    en_v = 3'b001; em_v = '0; sat_v = 1'b1; clr(3'b001);
    ev_v = 6'b000100; repeat (MAXV + 2) step();
    ev_v = '0; snap(); rd(0, v);
    chk("sat_value", v, MAXV);
    chk("sat_flag", int'(bus.overflow_flag[0]), 1);
    sat_v = 1'b0; clr(3'b001);
    ev_v = 6'b000100; repeat (MAXV + 2) step();
    ev_v = '0; snap(); rd(0, v);
    chk("wrap_value", v, 1);
    chk("wrap_flag", int'(bus.overflow_flag[0]), 1);
    clr(3'b001); snap(); rd(0, v);
    chk("clear_value", v, 0);
    chk("clear_flag", int'(bus.overflow_flag[0]), 0);

    // clear beats hit; snapshot takes the pre-increment value
    ev_v = 6'b000100; repeat (7) step();
    clr_v = 3'b001; step(); clr_v = '0;
    ev_v = '0; snap(); rd(0, v); chk("clear_vs_hit", v, 0);
    ev_v = 6'b000100; repeat (7) step();
    snap_v = 1'b1; step(); snap_v = 1'b0; ev_v = '0;
    rd(0, v); chk("snap_vs_hit_shadow", v, 7);
    snap(); rd(0, v); chk("snap_vs_hit_live", v, 8);

    // alarm pulses
    th_v = 6'd3; clr(3'b001); cnt = 0; pos = 0;
    for (int i = 1; i <= 6; i++) begin
      ev_v = (i <= 5) ? 6'b000100 : 6'b000000; step();
      if (bus.alarm[0]) begin cnt++; pos = i; end
    end
    chk("alarm_count", cnt, 1); chk("alarm_pos", pos, 3);
    th_v = '0; clr(3'b001); cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      ev_v = (i <= 5) ? 6'b000100 : 6'b000000; step();
      if (bus.alarm[0]) cnt++;
    end
    chk("alarm_disabled", cnt, 0);
    th_v = 6'd3; clr(3'b001); cnt = 0; pos = 0;
    for (int i = 1; i <= MAXV + 6; i++) begin
      ev_v = (i <= MAXV + 5) ? 6'b000100 : 6'b000000; step();
      if (bus.alarm[0]) begin cnt++; pos = i; end
    end
    chk("alarm_wrap_count", cnt, 2); chk("alarm_wrap_pos", pos, MAXV + 4);

    // out-of-range select and read index
    th_v = '0; set_sel(2, 7); en_v = 3'b100; clr(3'b100);
    ev_v = '1; repeat (5) step();
    ev_v = '0; snap();
    rd(2, v); chk("sel_out_of_range", v, 0);
    rd(3, v); chk("idx_out_of_range", v, 0);

    // random traffic
    en_v = '1;
    for (int k = 0; k < NC; k++) set_sel(k, $urandom_range(0, NE - 1));
    for (int n = 0; n < 3000; n++) begin
      ev_v   = NE'($urandom);
      if ($urandom_range(0, 15) == 0) em_v = NE'($urandom);
      if ($urandom_range(0, 15) == 0) en_v = NC'($urandom);
      if ($urandom_range(0, 31) == 0) set_sel($urandom_range(0, NC - 1), $urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) sat_v = ~sat_v;
      if ($urandom_range(0, 63) == 0) th_v = ($urandom_range(0, 3) == 0) ? CW'(MAXV) : CW'($urandom_range(0, 8));
      clr_v  = ($urandom_range(0, 47) == 0) ? NC'($urandom) : '0;
      snap_v = ($urandom_range(0, 3) == 0);
      idx_v  = IW'($urandom_range(0, 3));
      step();
    end
    clr_v = '0; snap_v = 1'b0;

    // asynchronous reset mid-count, with an edge-mode line held high through it
    #2 reset = 1'b1;
    #1;
    chk("async_reset_rd_data", int'(bus.rd_data), 0);
    chk("async_reset_alarm", int'(bus.alarm), 0);
    chk("async_reset_overflow", int'(bus.overflow_flag), 0);
    sb.delete();
    model_reset();
    en_v = 3'b001; set_sel(0, 0); em_v = 6'b000001; ev_v = 6'b000001;
    th_v = '0; sat_v = 1'b0; idx_v = '0;
    drive();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) step();
    snap(); rd(0, v); chk("edge_after_reset", v, 1);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
